mem_request_agent: RTL and testbench



---
 rtl/mem_request_agent.sv | 153 +++++++++++++++
 tb/tb_mem_request_agent.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_agent.sv
// Requester-side front end for one arbiter port: queues local commands, requests
// the shared memory bus, issues up to BURST beats per grant, and abandons unanswered requests.
module mem_request_agent #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    input  logic                       cmd_we,
    output logic                       req,
    input  logic                       grant,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    output logic                       timeout_err,
    output logic [1:0]                 agent_state,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int BEAT_W = $clog2(BURST + 1);
    localparam int ENT_W  = ADDR_W + DATA_W + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_XFER    = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
    logic               terr_nxt;

    logic [ENT_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   head;
    logic               push;
    logic               pop;

    assign cmd_ready   = !reset && (count < FULL_CNT);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = mem_valid;
    assign fifo_count  = count;
    assign agent_state = state;
    assign head        = fifo_mem[rd_ptr];

    // req comes only from registered state so the arbiter never sees a loop through grant.
    assign req       = (state == S_REQ) || (state == S_XFER);
    assign mem_valid = (state == S_XFER) && grant && (count != '0);
    assign mem_addr  = mem_valid ? head[ENT_W-1 -: ADDR_W] : '0;
    assign mem_wdata = mem_valid ? head[DATA_W:1] : '0;
    assign mem_we    = mem_valid ? head[0] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_addr, cmd_wdata, cmd_we};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            beat_cnt    <= beat_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        terr_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                wait_nxt = '0;
                beat_nxt = '0;
                if (count != '0) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (grant) begin
                    state_nxt = S_XFER;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_RELEASE;
                    terr_nxt  = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_XFER: begin
                if (mem_valid) begin
                    beat_nxt = beat_cnt + 1'b1;
                    // A beat racing a push leaves the queue non-empty, so the burst continues.
                    if ((beat_cnt == BEAT_LAST) || ((count == ONE_CNT) && !push)) begin
                        state_nxt = S_RELEASE;
                    end
                end else begin
                    state_nxt = S_RELEASE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_request_agent.sv
// Directed bench for mem_request_agent; a model arbiter grants whenever arb_en is set and req is high.
module tb_mem_request_agent;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_we;
    logic       req;
    logic       grant;
    logic       mem_valid;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       timeout_err;
    logic [1:0] agent_state;
    logic [2:0] fifo_count;
    logic       arb_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign grant = arb_en && req;

    mem_request_agent #(
        .DEPTH(4), .ADDR_W(8), .DATA_W(8), .BURST(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_we(cmd_we),
        .req(req), .grant(grant),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .timeout_err(timeout_err), .agent_state(agent_state), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Command k carries wdata k+0x80 and we = bit 0 of the address.
    task automatic set_cmd(input logic [7:0] a);
        cmd_addr  = a;
        cmd_wdata = a + 8'h80;
        cmd_we    = a[0];
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; arb_en = 1'b0;
        set_cmd(8'h77);

        // 1: reset with cmd_valid high
        repeat (2) begin
            step();
            chk("rst_ready", 32'(cmd_ready), 32'd0);
            chk("rst_req", 32'(req), 32'd0);
            chk("rst_state", 32'(agent_state), 32'd0);
            chk("rst_count", 32'(fifo_count), 32'd0);
            chk("rst_mv", 32'(mem_valid), 32'd0);
            chk("rst_terr", 32'(timeout_err), 32'd0);
        end
        reset = 1'b0; cmd_valid = 1'b0; #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("count_after_rst", 32'(fifo_count), 32'd0);

        // 2: single write
        arb_en = 1'b1; cmd_valid = 1'b1;
        cmd_addr = 8'h10; cmd_wdata = 8'hA5; cmd_we = 1'b1;
        step(); cmd_valid = 1'b0; #1;
        chk("t2_count", 32'(fifo_count), 32'd1);
        chk("t2_s_idle", 32'(agent_state), 32'd0);
        chk("t2_req0", 32'(req), 32'd0);
        step();
        chk("t2_s_req", 32'(agent_state), 32'd1);
        chk("t2_req1", 32'(req), 32'd1);
        step();
        chk("t2_s_xfer", 32'(agent_state), 32'd2);
        chk("t2_mv", 32'(mem_valid), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'h10);
        chk("t2_wdata", 32'(mem_wdata), 32'hA5);
        chk("t2_we", 32'(mem_we), 32'd1);
        step();
        chk("t2_s_rel", 32'(agent_state), 32'd3);
        chk("t2_rel_req", 32'(req), 32'd0);
        chk("t2_rel_mv", 32'(mem_valid), 32'd0);
        chk("t2_rel_count", 32'(fifo_count), 32'd0);
        step();
        chk("t2_s_idle2", 32'(agent_state), 32'd0);
        chk("t2_idle_req", 32'(req), 32'd0);
        step();
        chk("t2_stay_idle", 32'(agent_state), 32'd0);
        chk("t2_no_beat", 32'(mem_valid), 32'd0);
        chk("t2_addr_zero", 32'(mem_addr), 32'd0);

        // 3: five pushes into a 4-deep queue
        arb_en = 1'b0; cmd_valid = 1'b1; set_cmd(8'h01);
        step(); set_cmd(8'h02); #1;
        chk("t3_count1", 32'(fifo_count), 32'd1);
        step(); set_cmd(8'h03); #1;
        chk("t3_count2", 32'(fifo_count), 32'd2);
        chk("t3_s_req", 32'(agent_state), 32'd1);
        step(); set_cmd(8'h04); #1;
        chk("t3_count3", 32'(fifo_count), 32'd3);
        step(); set_cmd(8'h05); arb_en = 1'b1; #1;
        chk("t3_count4", 32'(fifo_count), 32'd4);
        chk("t3_full_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t3_b1_mv", 32'(mem_valid), 32'd1);
        chk("t3_b1_addr", 32'(mem_addr), 32'h01);
        chk("t3_b1_wdata", 32'(mem_wdata), 32'h81);
        chk("t3_b1_we", 32'(mem_we), 32'd1);
        chk("t3_b1_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t3_b2_addr", 32'(mem_addr), 32'h02);
        chk("t3_b2_we", 32'(mem_we), 32'd0);
        chk("t3_b2_count", 32'(fifo_count), 32'd3);
        chk("t3_b2_ready", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0; #1;
        chk("t3_b3_addr", 32'(mem_addr), 32'h03);
        chk("t3_b3_count", 32'(fifo_count), 32'd3);
        step();
        chk("t3_b4_addr", 32'(mem_addr), 32'h04);
        chk("t3_b4_count", 32'(fifo_count), 32'd2);
        step();
        chk("t3_rel_state", 32'(agent_state), 32'd3);
        chk("t3_rel_req", 32'(req), 32'd0);
        chk("t3_rel_mv", 32'(mem_valid), 32'd0);
        chk("t3_rel_count", 32'(fifo_count), 32'd1);
        step();
        chk("t3_idle_req", 32'(req), 32'd0);
        step();
        chk("t3_rereq", 32'(req), 32'd1);
        step();
        chk("t3_b5_mv", 32'(mem_valid), 32'd1);
        chk("t3_b5_addr", 32'(mem_addr), 32'h05);
        chk("t3_b5_wdata", 32'(mem_wdata), 32'h85);
        step();
        chk("t3_end_state", 32'(agent_state), 32'd3);
        chk("t3_end_count", 32'(fifo_count), 32'd0);
        step();
        chk("t3_end_idle", 32'(agent_state), 32'd0);

        // 4: no grant -> timeout
        arb_en = 1'b0; cmd_valid = 1'b1; set_cmd(8'h20);
        step(); cmd_valid = 1'b0; #1;
        chk("t4_req0", 32'(req), 32'd0);
        step();
        for (int i = 0; i < 15; i++) begin
            chk("t4_req_hi", 32'(req), 32'd1);
            chk("t4_no_err", 32'(timeout_err), 32'd0);
            step();
        end
        chk("t4_req_drop", 32'(req), 32'd0);
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk("t4_rel_state", 32'(agent_state), 32'd3);
        chk("t4_kept", 32'(fifo_count), 32'd1);
        step();
        chk("t4_req_low2", 32'(req), 32'd0);
        chk("t4_terr_once", 32'(timeout_err), 32'd0);
        chk("t4_kept2", 32'(fifo_count), 32'd1);
        step();
        chk("t4_rereq", 32'(req), 32'd1);
        arb_en = 1'b1;
        step();
        chk("t4_drain_mv", 32'(mem_valid), 32'd1);
        chk("t4_drain_addr", 32'(mem_addr), 32'h20);
        step(); arb_en = 1'b0; #1;
        chk("t4_drain_count", 32'(fifo_count), 32'd0);
        step();

        // 5: grant withdrawn after two beats
        cmd_valid = 1'b1; set_cmd(8'h01);
        step(); set_cmd(8'h02);
        step(); set_cmd(8'h03);
        step(); set_cmd(8'h04);
        step(); cmd_valid = 1'b0; arb_en = 1'b1; #1;
        chk("t5_count4", 32'(fifo_count), 32'd4);
        step();
        chk("t5_b1_addr", 32'(mem_addr), 32'h01);
        step();
        chk("t5_b2_addr", 32'(mem_addr), 32'h02);
        step(); arb_en = 1'b0; #1;
        chk("t5_nogrant_mv", 32'(mem_valid), 32'd0);
        chk("t5_nogrant_count", 32'(fifo_count), 32'd2);
        step();
        chk("t5_rel_state", 32'(agent_state), 32'd3);
        chk("t5_rel_count", 32'(fifo_count), 32'd2);
        step();
        step(); arb_en = 1'b1; #1;
        chk("t5_rereq", 32'(req), 32'd1);
        step();
        chk("t5_b3_addr", 32'(mem_addr), 32'h03);
        chk("t5_b3_mv", 32'(mem_valid), 32'd1);
        step();
        chk("t5_b4_addr", 32'(mem_addr), 32'h04);
        step();
        chk("t5_end_count", 32'(fifo_count), 32'd0);
        step();

        // 6: reset in the middle of a burst
        arb_en = 1'b0; cmd_valid = 1'b1; set_cmd(8'h01);
        step(); set_cmd(8'h02);
        step(); set_cmd(8'h03);
        step(); set_cmd(8'h04);
        step(); cmd_valid = 1'b0; arb_en = 1'b1;
        step();
        chk("t6_b1_addr", 32'(mem_addr), 32'h01);
        step();
        chk("t6_b2_addr", 32'(mem_addr), 32'h02);
        reset = 1'b1; #1;
        chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t6_req", 32'(req), 32'd0);
        chk("t6_mv", 32'(mem_valid), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_state", 32'(agent_state), 32'd0);
        reset = 1'b0;
        step();
        chk("t6_after_mv", 32'(mem_valid), 32'd0);
        chk("t6_after_req", 32'(req), 32'd0);
        step();
        chk("t6_still_idle", 32'(agent_state), 32'd0);
        chk("t6_still_mv", 32'(mem_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
